// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - Morse symbol/ASCII constants, FSM states and code lookup (MORSE_PUNCT_EN adds punctuation)
package morse_pkg;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam logic [7:0] CH_SPACE   = 8'h20;
    localparam logic [7:0] CH_INVALID = 8'h3F;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SPACE
    } state_t;

    typedef struct packed {
        logic       ok;
        logic [7:0] ch;
    } lookup_t;

    // The key places a sentinel 1 above the first symbol so that codes of
    // different lengths never alias (e.g. "E" = 1_0, "I" = 1_00).
    function automatic lookup_t morse_lookup(input logic [3:0] len, input logic [7:0] code);
        logic [8:0] key;
        lookup_t    r;
        key  = (9'd1 << len) | {1'b0, code};
        r.ok = 1'b1;
        r.ch = CH_INVALID;
        case (key)
            9'b1_01:     r.ch = "A";
            9'b1_1000:   r.ch = "B";
            9'b1_1010:   r.ch = "C";
            9'b1_100:    r.ch = "D";
            9'b1_0:      r.ch = "E";
            9'b1_0010:   r.ch = "F";
            9'b1_110:    r.ch = "G";
            9'b1_0000:   r.ch = "H";
            9'b1_00:     r.ch = "I";
            9'b1_0111:   r.ch = "J";
            9'b1_101:    r.ch = "K";
            9'b1_0100:   r.ch = "L";
            9'b1_11:     r.ch = "M";
            9'b1_10:     r.ch = "N";
            9'b1_111:    r.ch = "O";
            9'b1_0110:   r.ch = "P";
            9'b1_1101:   r.ch = "Q";
            9'b1_010:    r.ch = "R";
            9'b1_000:    r.ch = "S";
            9'b1_1:      r.ch = "T";
            9'b1_001:    r.ch = "U";
            9'b1_0001:   r.ch = "V";
            9'b1_011:    r.ch = "W";
            9'b1_1001:   r.ch = "X";
            9'b1_1011:   r.ch = "Y";
            9'b1_1100:   r.ch = "Z";
            9'b1_11111:  r.ch = "0";
            9'b1_01111:  r.ch = "1";
            9'b1_00111:  r.ch = "2";
            9'b1_00011:  r.ch = "3";
            9'b1_00001:  r.ch = "4";
            9'b1_00000:  r.ch = "5";
            9'b1_10000:  r.ch = "6";
            9'b1_11000:  r.ch = "7";
            9'b1_11100:  r.ch = "8";
            9'b1_11110:  r.ch = "9";
            9'b1_10010:  r.ch = "/";
            9'b1_10001:  r.ch = "=";
            9'b1_01010:  r.ch = "+";
`ifdef MORSE_PUNCT_EN
            9'b1_010101: r.ch = ".";
            9'b1_110011: r.ch = ",";
            9'b1_001100: r.ch = "?";
            9'b1_011110: r.ch = "'";
            9'b1_100001: r.ch = "-";
`endif
            default:     r.ok = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// rtl/morse_char_fifo.sv - first-word-fall-through character FIFO with fill count and sticky overflow
module morse_char_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     not_empty,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign not_empty = (fill != '0);
    assign full      = (fill == (AW+1)'(DEPTH));
    assign do_pop    = pop & not_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push   = push & (~full | do_pop);
    assign head      = not_empty ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (push && !do_push) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/morse_decoder_stream.sv
// rtl/morse_decoder_stream.sv - Morse symbol accumulator/decoder feeding an ASCII FIFO (MORSE_PUNCT_EN adds punctuation)
module morse_decoder_stream
    import morse_pkg::*;
#(
    parameter int         MAX_SYMS     = 6,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] INVALID_CHAR = CH_INVALID
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          valid,
    input  logic                          dot,
    input  logic                          dash,
    input  logic                          lg,
    input  logic                          wg,
    output logic [7:0]                    dout,
    output logic                          dvalid,
    input  logic                          dready,
    output logic                          error,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);
    localparam logic [3:0] LEN_MAX = 4'(MAX_SYMS);

    generate
        if (MAX_SYMS < 5 || MAX_SYMS > 8) begin : g_bad_syms
            $error("MAX_SYMS must be in 5..8");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two >= 2");
        end
`ifdef MORSE_PUNCT_EN
        if (MAX_SYMS < 6) begin : g_bad_punct
            $error("punctuation decoding needs MAX_SYMS >= 6");
        end
`endif
    endgenerate

    state_t              state;
    logic [MAX_SYMS-1:0] code;
    logic [3:0]          len;
    logic                overlong;
    logic                space_pend;

    logic                sym_take;
    logic                conflict;
    logic                gap;
    logic [MAX_SYMS-1:0] code_n;
    logic [3:0]          len_n;
    logic                ovl_n;
    logic                have_char;
    logic [7:0]          code_ext;
    lookup_t             lk;
    logic                char_bad;
    logic [7:0]          char_val;
    logic                push;
    logic [7:0]          push_data;
    logic                push_err;

    assign sym_take = valid & (dot ^ dash);
    assign conflict = valid & dot & dash;
    assign gap      = lg | wg;

    // Symbol arriving with a gap strobe is folded in before the lookup.
    always_comb begin
        code_n = code;
        len_n  = len;
        ovl_n  = overlong;
        if (conflict) begin
            ovl_n = 1'b1;
        end else if (sym_take) begin
            if (len < LEN_MAX) begin
                code_n = {code[MAX_SYMS-2:0], dash};
                len_n  = len + 4'd1;
            end else begin
                ovl_n = 1'b1;
            end
        end
    end

    always_comb begin
        code_ext                = '0;
        code_ext[MAX_SYMS-1:0]  = code_n;
    end

    assign lk        = morse_lookup(len_n, code_ext);
    assign have_char = (len_n != 4'd0) | ovl_n;
    assign char_bad  = ovl_n | ~lk.ok;
    assign char_val  = char_bad ? INVALID_CHAR : lk.ch;

    always_comb begin
        push      = 1'b0;
        push_data = CH_SPACE;
        push_err  = 1'b0;
        if (state == SPACE) begin
            push = space_pend;
        end else if (gap) begin
            if (have_char) begin
                push      = 1'b1;
                push_data = char_val;
                push_err  = char_bad;
            end else if (wg) begin
                push = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            code       <= '0;
            len        <= '0;
            overlong   <= 1'b0;
            space_pend <= 1'b0;
            error      <= 1'b0;
        end else begin
            error <= push_err | conflict;
            if (state != SPACE && gap) begin
                code     <= '0;
                len      <= '0;
                overlong <= 1'b0;
                if (wg && have_char) begin
                    state      <= SPACE;
                    space_pend <= 1'b1;
                end else begin
                    state <= IDLE;
                end
            end else begin
                // Includes SPACE: the space is pushed while a new symbol is still captured.
                code       <= code_n;
                len        <= len_n;
                overlong   <= ovl_n;
                space_pend <= 1'b0;
                state      <= have_char ? ACCUM : IDLE;
            end
        end
    end

    morse_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (push),
        .push_data (push_data),
        .pop       (dready),
        .head      (dout),
        .not_empty (dvalid),
        .overflow  (overflow),
        .fill      (fill)
    );

endmodule

// File: tb/tb_morse_decoder_stream.sv
// tb/tb_morse_decoder_stream.sv - scoreboard bench for morse_decoder_stream
module tb_morse_decoder_stream;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       valid = 1'b0;
    logic       dot = 1'b0;
    logic       dash = 1'b0;
    logic       lg = 1'b0;
    logic       wg = 1'b0;
    logic       dready = 1'b0;
    logic [7:0] dout;
    logic       dvalid;
    logic       error;
    logic       overflow;
    logic [2:0] fill;

    int         errors = 0;
    int         checks = 0;
    int         err_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    always #5 clk = ~clk;

    morse_decoder_stream dut (
        .clk      (clk),
        .clr      (clr),
        .valid    (valid),
        .dot      (dot),
        .dash     (dash),
        .lg       (lg),
        .wg       (wg),
        .dout     (dout),
        .dvalid   (dvalid),
        .dready   (dready),
        .error    (error),
        .overflow (overflow),
        .fill     (fill)
    );

    // Scoreboard: every accepted output byte is matched against the expected queue.
    always @(negedge clk) begin
        if (error) err_cnt++;
        if (!clr && dvalid && dready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_extra got=%h required=none", dout);
            end else begin
                exp_b = exp_q.pop_front();
                if (dout !== exp_b) begin
                    errors++;
                    $display("FAIL stream_char got=%h required=%h", dout, exp_b);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sym(input logic is_dash);
        valid = 1'b1; dot = ~is_dash; dash = is_dash;
        tick();
        valid = 1'b0; dot = 1'b0; dash = 1'b0;
    endtask

    task automatic do_lg;
        lg = 1'b1;
        tick();
        lg = 1'b0;
    endtask

    task automatic do_wg;
        wg = 1'b1;
        tick();
        wg = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks += 5;
        if (dout !== 8'h00)    begin errors++; $display("FAIL reset_dout got=%h required=00", dout); end
        if (dvalid !== 1'b0)   begin errors++; $display("FAIL reset_dvalid got=%b required=0", dvalid); end
        if (error !== 1'b0)    begin errors++; $display("FAIL reset_error got=%b required=0", error); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b required=0", overflow); end
        if (fill !== 3'd0)     begin errors++; $display("FAIL reset_fill got=%0d required=0", fill); end
        tick();
        clr = 1'b0;
        tick();
    endtask

    task automatic test_letter;
        dready = 1'b1;
        sym(0); sym(1);
        exp_q.push_back(8'h41);
        do_lg();
        checks += 3;
        if (dout !== 8'h41)  begin errors++; $display("FAIL letter_a_dout got=%h required=41", dout); end
        if (dvalid !== 1'b1) begin errors++; $display("FAIL letter_a_dvalid got=%b required=1", dvalid); end
        if (error !== 1'b0)  begin errors++; $display("FAIL letter_a_error got=%b required=0", error); end
        tick();
        checks++;
        if (dvalid !== 1'b0) begin errors++; $display("FAIL letter_a_one_cycle got=%b required=0", dvalid); end
    endtask

    task automatic test_word_gap;
        repeat (4) sym(0);
        sym(1);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h20);
        do_wg();
        checks++;
        if (dout !== 8'h34) begin errors++; $display("FAIL wg_char got=%h required=34", dout); end
        tick();
        checks += 2;
        if (dout !== 8'h20) begin errors++; $display("FAIL wg_space got=%h required=20", dout); end
        if (fill !== 3'd1)  begin errors++; $display("FAIL wg_fill got=%0d required=1", fill); end
        tick();
    endtask

    task automatic test_overlong;
        int e0;
        e0 = err_cnt;
        repeat (7) sym(0);
        exp_q.push_back(8'h3F);
        do_lg();
        checks += 2;
        if (dout !== 8'h3F) begin errors++; $display("FAIL overlong_dout got=%h required=3f", dout); end
        if (error !== 1'b1) begin errors++; $display("FAIL overlong_error got=%b required=1", error); end
        tick();
        sym(1);
        exp_q.push_back(8'h54);
        do_lg();
        checks += 2;
        if (dout !== 8'h54) begin errors++; $display("FAIL after_overlong got=%h required=54", dout); end
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL overlong_pulses got=%0d required=1", err_cnt - e0); end
        tick();
    endtask

    task automatic test_overflow;
        int n;
        dready = 1'b0;
        sym(0);         exp_q.push_back(8'h45); do_lg();
        sym(1);         exp_q.push_back(8'h54); do_lg();
        sym(0); sym(0); exp_q.push_back(8'h49); do_lg();
        sym(1); sym(1); exp_q.push_back(8'h4D); do_lg();
        sym(1); sym(0); do_lg();
        checks += 3;
        if (fill !== 3'd4)     begin errors++; $display("FAIL ovf_fill got=%0d required=4", fill); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b required=1", overflow); end
        if (dout !== 8'h45)    begin errors++; $display("FAIL ovf_head got=%h required=45", dout); end
        sym(1);
        dready = 1'b1;
        exp_q.push_back(8'h54);
        do_lg();
        checks++;
        if (fill !== 3'd4) begin errors++; $display("FAIL full_push_pop_fill got=%0d required=4", fill); end
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin tick(); n++; end
        checks += 3;
        if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_drain_timeout got=%0d required=0", exp_q.size()); end
        if (fill !== 3'd0)     begin errors++; $display("FAIL ovf_drained_fill got=%0d required=0", fill); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b required=1", overflow); end
    endtask

    task automatic test_clear_mid;
        dready = 1'b0;
        sym(0); do_lg();
        sym(1); sym(0);
        exp_q.delete();
        clr = 1'b1;
        #1;
        checks += 3;
        if (fill !== 3'd0)     begin errors++; $display("FAIL clr_fill got=%0d required=0", fill); end
        if (dvalid !== 1'b0)   begin errors++; $display("FAIL clr_dvalid got=%b required=0", dvalid); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow got=%b required=0", overflow); end
        tick();
        clr = 1'b0;
        dready = 1'b1;
        sym(0);
        exp_q.push_back(8'h45);
        do_lg();
        checks++;
        if (dout !== 8'h45) begin errors++; $display("FAIL clr_then_e got=%h required=45", dout); end
        tick();
        checks++;
        if (fill !== 3'd0) begin errors++; $display("FAIL clr_only_e got=%0d required=0", fill); end
    endtask

    task automatic test_punct;
        int e0;
        e0 = err_cnt;
        sym(0); sym(1); sym(0); sym(1); sym(0); sym(1);
`ifdef MORSE_PUNCT_EN
        exp_q.push_back(8'h2E);
        do_lg();
        tick();
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL punct_error got=%0d required=0", err_cnt - e0); end
`else
        exp_q.push_back(8'h3F);
        do_lg();
        tick();
        checks++;
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL punct_error got=%0d required=1", err_cnt - e0); end
`endif
    endtask

    task automatic test_back_to_back;
        int e0;
        do_lg();
        checks++;
        if (dvalid !== 1'b0) begin errors++; $display("FAIL idle_lg_ignored got=%b required=0", dvalid); end
        exp_q.push_back(8'h20);
        do_wg();
        checks++;
        if (dout !== 8'h20) begin errors++; $display("FAIL idle_wg_space got=%h required=20", dout); end
        sym(0);
        valid = 1'b1; dash = 1'b1; lg = 1'b1;
        exp_q.push_back(8'h41);
        tick();
        valid = 1'b0; dash = 1'b0; lg = 1'b0;
        checks++;
        if (dout !== 8'h41) begin errors++; $display("FAIL sym_with_lg got=%h required=41", dout); end
        e0 = err_cnt;
        valid = 1'b1; dot = 1'b1; dash = 1'b1;
        tick();
        valid = 1'b0; dot = 1'b0; dash = 1'b0;
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL conflict_pulse got=%b required=1", error); end
        exp_q.push_back(8'h3F);
        do_lg();
        tick(); tick();
        checks++;
        if (err_cnt - e0 !== 2) begin errors++; $display("FAIL conflict_pulses got=%0d required=2", err_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_letter();
        test_word_gap();
        test_overlong();
        test_overflow();
        test_clear_mid();
        test_punct();
        test_back_to_back();
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expected got=%0d required=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/morse_decoder_stream.md
Name: morse_decoder_stream

Overview:
- Parametrised successor to the team's single-character Morse decoder.
- Accumulates dot/dash symbols into a length-tagged code register and decodes on a letter gap (lg) or word gap (wg).
- Pushes ASCII characters, including a space for each word gap, into an internal output FIFO with a valid/ready handshake, so back-to-back characters are never lost.
- Reports invalid, overlong and overflow conditions separately. Sits between the symbol-timing front end and the UART/text sink.

Parameters:
- MAX_SYMS, 6, maximum symbols per character (legal range 5..8).
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2).
- INVALID_CHAR, 8'h3F, ASCII code emitted for an undecodable or overlong code ('?').

Ports:
- clk  in  1  system clock, all state on posedge.
- clr  in  1  reset, asynchronous, active-high.
- valid  in  1  symbol strobe; dot/dash are sampled only when valid=1.
- dot  in  1  symbol is a dot (bit 0).
- dash  in  1  symbol is a dash (bit 1).
- lg  in  1  letter-gap strobe, one clk wide.
- wg  in  1  word-gap strobe, one clk wide.
- dout  out  8  ASCII head of FIFO.
- dvalid  out  1  dout holds a valid entry.
- dready  in  1  sink accepts dout; a pop occurs when dvalid&dready.
- error  out  1  one-cycle pulse on each invalid/overlong push or symbol conflict.
- overflow  out  1  sticky; set when a push is dropped because the FIFO is full.
- fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (clr=1, async): code=0, len=0, overlong=0, space_pend=0, FIFO empty, dout=8'h00, dvalid=0, error=0, overflow=0, fill=0. State returns to IDLE immediately, mid-character included. The overflow flag clears only on clr.
- Symbol capture:
  - valid & (dot^dash): code = {code, dash}, len++.
  - When len==MAX_SYMS, further symbols set overlong and do not shift.
  - valid & dot & dash: symbol ignored, error pulses, overlong=1 (character is poisoned).
  - valid with neither dot nor dash: no effect.
- Lookup: a combinational function of (len, code) returning standard ITU letters A-Z, digits 0-9, and '/', '=', '+'. Any other code returns INVALID_CHAR and flags invalid.
- FSM states:
  - IDLE: len==0. Symbol goes to ACCUM. wg pushes a space (8'h20). lg is ignored.
  - ACCUM: symbols accumulate. lg: push lookup (or INVALID_CHAR if overlong), clear code/len/overlong, go to IDLE. wg: push the character, set space_pend, go to SPACE.
  - SPACE: push 8'h20, clear space_pend, go to IDLE. A symbol arriving this cycle is captured normally, so the next state is ACCUM if a symbol was taken.
- Priority: clr > lg/wg > symbol.
  - A symbol in the same cycle as lg/wg belongs to the character being closed: it is appended before lookup.
  - lg and wg together are treated as wg.
- Latency: gap strobe at edge N → entry written at edge N; dvalid=1 and dout valid after edge N (first-word-fall-through). The SPACE entry follows one cycle later.
- FIFO:
  - A push when full is dropped and sets overflow.
  - A push and pop in the same cycle when full succeeds; fill is unchanged.
  - A pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- error pulses in the cycle its push is written: invalid, overlong, or conflict push. A symbol conflict pulses immediately.

Optional Feature:
- MORSE_PUNCT_EN defined: the lookup adds 6-symbol punctuation: '.' (.-.-.-), ',' (--..--), '?' (..--..), ''' (.----.), '-' (-....-). This requires MAX_SYMS≥6 (elaboration assertion).
- Undefined: those codes decode to INVALID_CHAR with an error pulse.

Decomposition:
- Package morse_pkg holds:
  - symbol encoding constants (SYM_DOT=0, SYM_DASH=1);
  - ASCII constants (CH_SPACE, CH_INVALID default);
  - the FSM state enum (IDLE, ACCUM, SPACE);
  - the lookup function morse_lookup(len, code).
- One sub-module: morse_char_fifo (parametrised FWFT FIFO with full/empty/fill).

Test Plan:
- Dot, dash, lg, with dready=1 → dout=8'h41 ('A'), dvalid for 1 cycle, error=0.
- Dot×4, dash, wg → 8'h34 ('4') then 8'h20 on consecutive cycles.
- Dot×7, lg (MAX_SYMS=6) → 8'h3F, error pulse; next code dash, lg → 8'h54 ('T').
- dready=0, push 5 letters (FIFO_DEPTH=4) → fill=4, overflow=1, first 4 characters intact in order after dready=1.
- Dash, dot, then clr mid-character, then dot, lg → 8'h45 ('E') only; fill returns to 0 at clr.
- .-.-.- then lg → 8'h2E with MORSE_PUNCT_EN; 8'h3F plus error pulse without it.
